// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: symbol encoding, FSM states,
// lookup result layout and a helper that left-aligns a symbol pattern.
package morse_pkg;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMBOLS = 6;

    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] CASE_FOLD_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ISPACE,
        CGAP,
        WGAP
    } state_e;

    typedef struct packed {
        logic [MAX_SYMBOLS-1:0] code;      // first symbol in the MSB
        logic [2:0]             len;
        logic                   is_space;
        logic                   supported;
    } lut_out_t;

    // Patterns are written right-aligned for readability and stored MSB-first.
    function automatic lut_out_t sym(input logic [2:0] len, input logic [MAX_SYMBOLS-1:0] bits_r);
        lut_out_t r;
        r.code      = bits_r << (MAX_SYMBOLS - int'(len));
        r.len       = len;
        r.is_space  = 1'b0;
        r.supported = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII-to-Morse lookup: letters (either case), digits, a small
// punctuation set and the word-space character.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] ascii_i,
    output lut_out_t   entry_o
);

    logic [7:0] ch;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        ch      = ascii_i;
        entry_o = '0;
        if (ascii_i >= "a" && ascii_i <= "z") begin
            ch = ascii_i - CASE_FOLD_OFFSET;
        end
        case (ch)
            "A": entry_o = sym(3'd2, 6'b01);
            "B": entry_o = sym(3'd4, 6'b1000);
            "C": entry_o = sym(3'd4, 6'b1010);
            "D": entry_o = sym(3'd3, 6'b100);
            "E": entry_o = sym(3'd1, 6'b0);
            "F": entry_o = sym(3'd4, 6'b0010);
            "G": entry_o = sym(3'd3, 6'b110);
            "H": entry_o = sym(3'd4, 6'b0000);
            "I": entry_o = sym(3'd2, 6'b00);
            "J": entry_o = sym(3'd4, 6'b0111);
            "K": entry_o = sym(3'd3, 6'b101);
            "L": entry_o = sym(3'd4, 6'b0100);
            "M": entry_o = sym(3'd2, 6'b11);
            "N": entry_o = sym(3'd2, 6'b10);
            "O": entry_o = sym(3'd3, 6'b111);
            "P": entry_o = sym(3'd4, 6'b0110);
            "Q": entry_o = sym(3'd4, 6'b1101);
            "R": entry_o = sym(3'd3, 6'b010);
            "S": entry_o = sym(3'd3, 6'b000);
            "T": entry_o = sym(3'd1, 6'b1);
            "U": entry_o = sym(3'd3, 6'b001);
            "V": entry_o = sym(3'd4, 6'b0001);
            "W": entry_o = sym(3'd3, 6'b011);
            "X": entry_o = sym(3'd4, 6'b1001);
            "Y": entry_o = sym(3'd4, 6'b1011);
            "Z": entry_o = sym(3'd4, 6'b1100);
            "0": entry_o = sym(3'd5, 6'b11111);
            "1": entry_o = sym(3'd5, 6'b01111);
            "2": entry_o = sym(3'd5, 6'b00111);
            "3": entry_o = sym(3'd5, 6'b00011);
            "4": entry_o = sym(3'd5, 6'b00001);
            "5": entry_o = sym(3'd5, 6'b00000);
            "6": entry_o = sym(3'd5, 6'b10000);
            "7": entry_o = sym(3'd5, 6'b11000);
            "8": entry_o = sym(3'd5, 6'b11100);
            "9": entry_o = sym(3'd5, 6'b11110);
            ".": entry_o = sym(3'd6, 6'b010101);
            ",": entry_o = sym(3'd6, 6'b110011);
            "?": entry_o = sym(3'd6, 6'b001100);
            "/": entry_o = sym(3'd5, 6'b10010);
            "=": entry_o = sym(3'd5, 6'b10001);
            ASCII_SPACE: begin
                entry_o.is_space  = 1'b1;
                entry_o.supported = 1'b1;
            end
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Sequential Morse transmitter: accepts one ASCII character at a time and keys
// it out with unit timing; supports word spaces, abort and unsupported-char flags.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       abort,
    output logic       key_out,
    output logic       busy,
    output logic       err_unsupported
);

    localparam int UCW = $clog2(UNIT_CYCLES + 1);
    localparam int ULW = $clog2(WORD_GAP_UNITS + DASH_UNITS + 1);

    localparam logic [UCW-1:0] UNIT_LAST = UCW'(UNIT_CYCLES - 1);
    localparam logic [ULW-1:0] DOT_LEFT  = '0;
    localparam logic [ULW-1:0] DASH_LEFT = ULW'(DASH_UNITS - 1);
    localparam logic [ULW-1:0] CGAP_LEFT = ULW'(CHAR_GAP_UNITS - 1);
    localparam logic [ULW-1:0] WGAP_LEFT = ULW'(WORD_GAP_UNITS - CHAR_GAP_UNITS - 1);

    state_e                 state_q, state_d;
    logic [UCW-1:0]         unit_cnt_q, unit_cnt_d;
    logic [ULW-1:0]         units_left_q, units_left_d;
    logic [MAX_SYMBOLS-1:0] code_q, code_d;
    logic [2:0]             len_q, len_d;
    logic [2:0]             sym_idx_q, sym_idx_d;
    logic                   key_q, key_d;
    logic                   err_q, err_d;

    lut_out_t lut;
    logic     transfer;
    logic     unit_done;
    logic     state_done;

    morse_lut u_lut (
        .ascii_i (in_data),
        .entry_o (lut)
    );

    function automatic logic [ULW-1:0] mark_left(input logic s);
        return (s == SYM_DASH) ? DASH_LEFT : DOT_LEFT;
    endfunction

    assign in_ready   = (state_q == IDLE) && rst_n;
    assign transfer   = in_valid && in_ready;
    assign unit_done  = (unit_cnt_q == UNIT_LAST);
    assign state_done = unit_done && (units_left_q == '0);

    // Each state lasts (units_left at entry + 1) units; counters reload on entry.
    always_comb begin
        state_d      = state_q;
        unit_cnt_d   = unit_done ? '0 : unit_cnt_q + UCW'(1);
        units_left_d = unit_done ? units_left_q - ULW'(1) : units_left_q;
        code_d       = code_q;
        len_d        = len_q;
        sym_idx_d    = sym_idx_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                unit_cnt_d   = '0;
                units_left_d = '0;
                if (transfer) begin
                    if (!lut.supported) begin
                        err_d = 1'b1;
                    end else if (lut.is_space) begin
                        state_d      = WGAP;
                        units_left_d = WGAP_LEFT;
                    end else begin
                        state_d      = MARK;
                        code_d       = lut.code;
                        len_d        = lut.len;
                        sym_idx_d    = '0;
                        units_left_d = mark_left(lut.code[MAX_SYMBOLS-1]);
                    end
                end
            end
            MARK: begin
                if (state_done) begin
                    if (sym_idx_q + 3'd1 < len_q) begin
                        state_d      = ISPACE;
                        units_left_d = '0;
                    end else begin
                        state_d      = CGAP;
                        units_left_d = CGAP_LEFT;
                    end
                end
            end
            ISPACE: begin
                if (state_done) begin
                    state_d      = MARK;
                    sym_idx_d    = sym_idx_q + 3'd1;
                    code_d       = code_q << 1;
                    units_left_d = mark_left(code_q[MAX_SYMBOLS-2]);
                end
            end
            CGAP, WGAP: begin
                if (state_done) begin
                    state_d      = IDLE;
                    units_left_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                unit_cnt_d   = '0;
                units_left_d = '0;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            unit_cnt_d   = '0;
            units_left_d = '0;
        end

        key_d = (state_d == MARK);
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather
    // than the sensitivity list; all state uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            unit_cnt_q   <= '0;
            units_left_q <= '0;
            code_q       <= '0;
            len_q        <= '0;
            sym_idx_q    <= '0;
            key_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_cnt_q   <= unit_cnt_d;
            units_left_q <= units_left_d;
            code_q       <= code_d;
            len_q        <= len_d;
            sym_idx_q    <= sym_idx_d;
            key_q        <= key_d;
            err_q        <= err_d;
        end
    end

    assign key_out         = key_q;
    assign busy            = (state_q != IDLE);
    assign err_unsupported = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: directed scenarios plus random characters
// compared against a dot/dash string model of the key waveform.
module tb_morse_keyer;

    localparam int U  = 4;
    localparam int DU = 3;
    localparam int CG = 3;
    localparam int WG = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       abort = 1'b0;
    logic       key_out;
    logic       busy;
    logic       err_unsupported;

    int n_cmp = 0;
    int n_err = 0;

    bit cap_key[$];
    bit cap_busy[$];
    bit exp_key[$];
    bit ref_key[$];
    int cap_lat;
    bit cap_err1;

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----."};

    morse_keyer #(
        .UNIT_CYCLES    (U),
        .DASH_UNITS     (DU),
        .CHAR_GAP_UNITS (CG),
        .WORD_GAP_UNITS (WG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .abort           (abort),
        .key_out         (key_out),
        .busy            (busy),
        .err_unsupported (err_unsupported)
    );

    always #5 clk = ~clk;

    // "" = unsupported, " " = word space, otherwise the dot/dash pattern.
    function automatic string morse_of(input byte unsigned c);
        byte unsigned u;
        u = c;
        if (u >= 8'd97 && u <= 8'd122) u = u - 8'd32;
        if (u >= 8'd65 && u <= 8'd90) return letters[u - 8'd65];
        if (u >= 8'd48 && u <= 8'd57) return digits[u - 8'd48];
        case (u)
            8'h2E:   return ".-.-.-";
            8'h2C:   return "--..--";
            8'h3F:   return "..--..";
            8'h2F:   return "-..-.";
            8'h3D:   return "-...-";
            8'h20:   return " ";
            default: return "";
        endcase
    endfunction

    // Expected key samples from the cycle after the transfer until in_ready returns.
    task automatic build_exp(input string p);
        exp_key.delete();
        if (p == " ") begin
            repeat ((WG - CG) * U) exp_key.push_back(1'b0);
        end else if (p != "") begin
            for (int i = 0; i < p.len(); i++) begin
                repeat ((p[i] == "-") ? DU * U : U) exp_key.push_back(1'b1);
                if (i != p.len() - 1) repeat (U) exp_key.push_back(1'b0);
            end
            repeat (CG * U) exp_key.push_back(1'b0);
        end
    endtask

    function automatic int wave_diff();
        int d;
        d = (cap_key.size() > exp_key.size()) ? cap_key.size() - exp_key.size()
                                              : exp_key.size() - cap_key.size();
        for (int i = 0; i < cap_key.size() && i < exp_key.size(); i++)
            if (cap_key[i] !== exp_key[i]) d++;
        return d;
    endfunction

    function automatic int busy_low_count();
        int d = 0;
        foreach (cap_busy[i]) if (cap_busy[i] !== 1'b1) d++;
        return d;
    endfunction

    // Waits for in_ready, transfers c, and returns at the negedge of cycle 1.
    task automatic start_char(input byte unsigned c);
        int k = 0;
        while (in_ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, k);
        end
        in_data  = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_char(input byte unsigned c);
        int k = 1;
        cap_key.delete();
        cap_busy.delete();
        start_char(c);
        cap_err1 = err_unsupported;
        cap_lat  = -1;
        while (k < 400) begin
            if (in_ready === 1'b1) begin
                cap_lat = k;
                break;
            end
            cap_key.push_back(key_out);
            cap_busy.push_back(busy);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({key_out, busy, err_unsupported, in_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: key/busy/err/ready=%b, required 0000",
                     {key_out, busy, err_unsupported, in_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_letter_e();
        build_exp(morse_of("E"));
        run_char("E");
        n_cmp++;
        if (cap_lat !== U * (1 + CG) + 1) begin
            n_err++;
            $display("FAIL e_latency: %0d cycles, required %0d", cap_lat, U * (1 + CG) + 1);
        end
        n_cmp++;
        if (wave_diff() != 0) begin
            n_err++;
            $display("FAIL e_wave: %0d sample errors over %0d samples", wave_diff(), cap_key.size());
        end
        n_cmp++;
        if (busy_low_count() != 0 || cap_busy.size() != 16) begin
            n_err++;
            $display("FAIL e_busy: %0d low of %0d samples, required 0 of 16",
                     busy_low_count(), cap_busy.size());
        end
    endtask

    task automatic test_digit_zero();
        build_exp(morse_of("0"));
        run_char("0");
        n_cmp++;
        if (cap_lat !== 5 * DU * U + 4 * U + CG * U + 1) begin
            n_err++;
            $display("FAIL zero_latency: %0d cycles, required %0d", cap_lat, 5 * DU * U + 4 * U + CG * U + 1);
        end
        n_cmp++;
        if (wave_diff() != 0) begin
            n_err++;
            $display("FAIL zero_wave: %0d sample errors", wave_diff());
        end
    endtask

    task automatic test_case_fold();
        int d = 0;
        run_char("a");
        ref_key = cap_key;
        run_char("A");
        if (ref_key.size() != cap_key.size()) d++;
        for (int i = 0; i < ref_key.size() && i < cap_key.size(); i++)
            if (ref_key[i] !== cap_key[i]) d++;
        n_cmp++;
        if (d != 0) begin
            n_err++;
            $display("FAIL fold_same: 'a' vs 'A' differ in %0d samples, required 0", d);
        end
        build_exp(".-");
        n_cmp++;
        if (wave_diff() != 0) begin
            n_err++;
            $display("FAIL fold_wave: %0d sample errors vs .-", wave_diff());
        end
    endtask

    // The two handshake cycles spent in IDLE add to the CGAP and WGAP lows.
    task automatic test_word_gap();
        byte unsigned seq[3] = '{"T", " ", "T"};
        bit smp[$];
        int idx = 1, p = 0, r1 = 0, r0 = 0, r2 = 0, k = 0;
        while (in_ready !== 1'b1) @(negedge clk);
        in_data  = seq[0];
        in_valid = 1'b1;
        while (k < 300) begin
            @(negedge clk);
            k++;
            smp.push_back(key_out);
            if (in_ready === 1'b1) begin
                if (idx < 3) begin
                    in_data = seq[idx];
                    idx++;
                end else begin
                    in_valid = 1'b0;
                    break;
                end
            end
        end
        in_valid = 1'b0;
        while (p < smp.size() && smp[p] == 1'b1) begin r1++; p++; end
        while (p < smp.size() && smp[p] == 1'b0) begin r0++; p++; end
        while (p < smp.size() && smp[p] == 1'b1) begin r2++; p++; end
        n_cmp++;
        if (r1 != DU * U || r2 != DU * U) begin
            n_err++;
            $display("FAIL wgap_marks: marks %0d and %0d cycles, required %0d", r1, r2, DU * U);
        end
        n_cmp++;
        if (r0 != CG * U + (WG - CG) * U + 2) begin
            n_err++;
            $display("FAIL wgap_low: key low %0d cycles, required %0d", r0, CG * U + (WG - CG) * U + 2);
        end
    endtask

    task automatic test_unsupported();
        start_char("#");
        n_cmp++;
        if ({err_unsupported, in_ready, key_out, busy} !== 4'b1100) begin
            n_err++;
            $display("FAIL unsup_flag: err/ready/key/busy=%b, required 1100",
                     {err_unsupported, in_ready, key_out, busy});
        end
        in_data  = "E";
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({err_unsupported, key_out, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL unsup_next: err/key/busy=%b, required 011", {err_unsupported, key_out, busy});
        end
    endtask

    task automatic test_abort();
        start_char("O");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (key_out !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: key=%b at cycle 6, required 1", key_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({key_out, in_ready, busy, err_unsupported} !== 4'b0100) begin
            n_err++;
            $display("FAIL abort_recover: key/ready/busy/err=%b, required 0100",
                     {key_out, in_ready, busy, err_unsupported});
        end
        // Abort while idle must not block a transfer.
        abort = 1'b1;
        start_char("E");
        abort = 1'b0;
        n_cmp++;
        if (key_out !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle: key=%b busy=%b, required 1 1", key_out, busy);
        end
    endtask

    task automatic test_reset_mid();
        start_char("O");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({key_out, busy, err_unsupported, in_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid: key/busy/err/ready=%b, required 0000",
                     {key_out, busy, err_unsupported, in_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || key_out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_release: ready=%b key=%b, required 1 0", in_ready, key_out);
        end
    endtask

    task automatic test_random();
        string pool = "AbcXyzKq09357.,?/= #@!*m";
        for (int n = 0; n < 24; n++) begin
            byte unsigned c;
            string p;
            c = pool[$urandom_range(0, pool.len() - 1)];
            p = morse_of(c);
            build_exp(p);
            run_char(c);
            n_cmp++;
            if (cap_lat !== exp_key.size() + 1) begin
                n_err++;
                $display("FAIL rand_latency '%s': %0d cycles, required %0d", c, cap_lat, exp_key.size() + 1);
            end
            n_cmp++;
            if (wave_diff() != 0 || busy_low_count() != 0) begin
                n_err++;
                $display("FAIL rand_wave '%s': %0d key errors, %0d busy-low samples, required 0 0",
                         c, wave_diff(), busy_low_count());
            end
            n_cmp++;
            if (cap_err1 !== (p == "")) begin
                n_err++;
                $display("FAIL rand_err '%s': err=%b, required %b", c, cap_err1, (p == ""));
            end
        end
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_digit_zero();
        test_case_fold();
        test_word_gap();
        test_unsupported();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
